// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and fetch FSM encodings for the instruction-fetch slice.
// Prefetch entries are {pc, inst} pairs; see fetch_unit.sv for the FETCH_PERF_CNT_EN option.
package fetch_unit_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus     = 32;

   localparam logic [InstBus-1:0] ZeroWord  = 32'h0000_0000;
   localparam logic               RstEnable = 1'b1;

   typedef enum logic [1:0] {
      FETCH_IDLE = 2'd0,
      FETCH_REQ  = 2'd1,
      FETCH_WAIT = 2'd2,
      FETCH_DROP = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic [InstAddrBus-1:0] pc;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

   function automatic logic [InstAddrBus-1:0] word_align(input logic [InstAddrBus-1:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO (fetch_fifo): synchronous, power-of-two depth, {pc, inst} entries.
// Supports simultaneous push/pop (including on a full FIFO) and a one-cycle clear.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int  FIFO_DEPTH = 2,
   localparam int PtrW       = $clog2(FIFO_DEPTH),
   localparam int CntW       = PtrW + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  fetch_entry_t    push_entry,
   input  logic            pop,
   input  logic            clear,
   output fetch_entry_t    head,
   output logic [CntW-1:0] count
);

   logic [PtrW-1:0] rd_ptr;
   logic [PtrW-1:0] wr_ptr;
   fetch_entry_t    mem [FIFO_DEPTH];
   logic            do_push;
   logic            do_pop;

   // A pop frees the slot in the same edge, so push is allowed on a full FIFO when popping.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CntW'(FIFO_DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (rst == RstEnable || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PtrW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PtrW'(1);
         count <= count + CntW'(do_push) - CntW'(do_pop);
      end
   end

   // NOTE: storage is deliberately not reset; count/pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: sequential PC generation, one-outstanding ROM req/ack, prefetch FIFO
// and registered IF/ID outputs. Define FETCH_PERF_CNT_EN to add the bubble_cnt_o counter.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] START_PC   = 32'h0000_0000,
   parameter int                     FIFO_DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [InstAddrBus-1:0] redirect_pc_i,
   output logic                   rom_req_o,
   output logic [InstAddrBus-1:0] rom_addr_o,
   input  logic                   rom_ack_i,
   input  logic [InstBus-1:0]     rom_data_i,
   output logic [InstAddrBus-1:0] pc_o,
   output logic [InstBus-1:0]     inst_o,
   output logic                   inst_valid_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            bubble_cnt_o
`endif
);

   localparam int                     CntW    = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CntW-1:0]        DepthC  = CntW'(FIFO_DEPTH);
   localparam logic [InstAddrBus-1:0] PcStep  = 32'd4;

   fetch_state_e           state;
   logic [InstAddrBus-1:0] fetch_pc;
   logic [InstAddrBus-1:0] target_pc;
   logic                   push;
   logic                   pop;
   fetch_entry_t           head;
   logic [CntW-1:0]        fifo_count;
   logic [CntW-1:0]        count_after;
   logic                   has_space;

   assign target_pc = word_align(redirect_pc_i);
   assign push      = (state == FETCH_REQ) && rom_ack_i && !redirect_i;
   assign pop       = !redirect_i && !stall_i && (fifo_count != '0);

   // NOTE: default first so every path assigns count_after and no latch is inferred.
   always_comb begin
      count_after = fifo_count + CntW'(push) - CntW'(pop);
      if (redirect_i) count_after = '0;
   end

   assign has_space = count_after < DepthC;

   fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_entry ('{pc: fetch_pc, inst: rom_data_i}),
      .pop        (pop),
      .clear      (redirect_i),
      .head       (head),
      .count      (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         state        <= FETCH_IDLE;
         fetch_pc     <= START_PC;
         rom_req_o    <= 1'b0;
         rom_addr_o   <= ZeroWord;
         pc_o         <= ZeroWord;
         inst_o       <= ZeroWord;
         inst_valid_o <= 1'b0;
      end else begin
         // Redirect forces a bubble even under stall; a stall alone holds the outputs.
         if (redirect_i || (!stall_i && !pop)) begin
            pc_o         <= ZeroWord;
            inst_o       <= ZeroWord;
            inst_valid_o <= 1'b0;
         end else if (pop) begin
            pc_o         <= head.pc;
            inst_o       <= head.inst;
            inst_valid_o <= 1'b1;
         end

         case (state)
            FETCH_IDLE: begin
               state      <= FETCH_REQ;
               rom_req_o  <= 1'b1;
               rom_addr_o <= redirect_i ? target_pc : fetch_pc;
               if (redirect_i) fetch_pc <= target_pc;
            end
            FETCH_REQ: begin
               if (rom_ack_i) begin
                  if (redirect_i) begin
                     fetch_pc   <= target_pc;
                     rom_addr_o <= target_pc;
                  end else begin
                     fetch_pc <= fetch_pc + PcStep;
                     if (has_space) begin
                        rom_addr_o <= fetch_pc + PcStep;
                     end else begin
                        state     <= FETCH_WAIT;
                        rom_req_o <= 1'b0;
                     end
                  end
               end else if (redirect_i) begin
                  // Old address stays on the bus until the ROM answers; that word is dropped.
                  fetch_pc <= target_pc;
                  state    <= FETCH_DROP;
               end
            end
            FETCH_WAIT: begin
               if (redirect_i || has_space) begin
                  state      <= FETCH_REQ;
                  rom_req_o  <= 1'b1;
                  rom_addr_o <= redirect_i ? target_pc : fetch_pc;
                  if (redirect_i) fetch_pc <= target_pc;
               end
            end
            FETCH_DROP: begin
               if (redirect_i) fetch_pc <= target_pc;
               if (rom_ack_i) begin
                  state      <= FETCH_REQ;
                  rom_addr_o <= redirect_i ? target_pc : fetch_pc;
               end
            end
            default: begin
               state     <= FETCH_IDLE;
               rom_req_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
         bubble_cnt_o <= 32'd0;
      end else if (!stall_i && !redirect_i && !pop && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
         bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: streaming, stall, delayed ack, redirect, reset, PC wrap.
// The ROM returns {16'hC0DE, addr[15:0]}; ack timing is driven by the bench.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        rom_req;
   logic [31:0] rom_addr;
   logic        rom_ack;
   logic [31:0] rom_data;
   logic [31:0] pc;
   logic [31:0] inst;
   logic        inst_valid;
   logic [31:0] bubble_cnt;

   logic        rst_w = 1'b1;
   logic        rom_req_w;
   logic [31:0] rom_addr_w;
   logic [31:0] rom_data_w;
   logic [31:0] pc_w;
   logic [31:0] inst_w;
   logic        inst_valid_w;
   logic [31:0] bubble_cnt_w;

   logic        ack_en = 1'b1;
   logic        ack_force = 1'b0;
   int          ack_delay = 0;
   int          wait_cnt = 0;

   int n_asserts = 0;
   int n_fail    = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   assign rom_data   = rom_word(rom_addr);
   assign rom_ack    = rom_req && (ack_force || (ack_en && (wait_cnt >= ack_delay)));
   assign rom_data_w = rom_word(rom_addr_w);

   always @(posedge clk) begin
      if (rst || !rom_req || rom_ack) wait_cnt <= 0;
      else                            wait_cnt <= wait_cnt + 1;
   end

   fetch_unit #(.START_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall_i       (stall),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .rom_req_o     (rom_req),
      .rom_addr_o    (rom_addr),
      .rom_ack_i     (rom_ack),
      .rom_data_i    (rom_data),
      .pc_o          (pc),
      .inst_o        (inst),
      .inst_valid_o  (inst_valid)
`ifdef FETCH_PERF_CNT_EN
      ,
      .bubble_cnt_o  (bubble_cnt)
`endif
   );

   fetch_unit #(.START_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
      .clk           (clk),
      .rst           (rst_w),
      .stall_i       (1'b0),
      .redirect_i    (1'b0),
      .redirect_pc_i (32'h0),
      .rom_req_o     (rom_req_w),
      .rom_addr_o    (rom_addr_w),
      .rom_ack_i     (rom_req_w),
      .rom_data_i    (rom_data_w),
      .pc_o          (pc_w),
      .inst_o        (inst_w),
      .inst_valid_o  (inst_valid_w)
`ifdef FETCH_PERF_CNT_EN
      ,
      .bubble_cnt_o  (bubble_cnt_w)
`endif
   );

`ifndef FETCH_PERF_CNT_EN
   assign bubble_cnt   = 32'h0;
   assign bubble_cnt_w = 32'h0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [31:0] epc, input logic [31:0] einst,
                            input logic evalid);
      check({tag, ".pc"}, pc, epc);
      check({tag, ".inst"}, inst, einst);
      check({tag, ".valid"}, {31'b0, inst_valid}, {31'b0, evalid});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(2);
      check_out("reset", 32'h0, 32'h0, 1'b0);
      check("reset.req", {31'b0, rom_req}, 32'h0);
      check("reset.addr", rom_addr, 32'h0);
      check("reset.wrap_pc", pc_w, 32'h0);
      rst = 1'b0;

      // Streaming with ack every cycle: first valid output three edges after reset release
      tick(1);
      check("e1.req", {31'b0, rom_req}, 32'h1);
      check("e1.addr", rom_addr, 32'h0);
      check("e1.valid", {31'b0, inst_valid}, 32'h0);
      tick(1);
      check("e2.valid", {31'b0, inst_valid}, 32'h0);
      tick(1);
      check_out("e3", 32'h0, rom_word(32'h0), 1'b1);
      tick(1);
      check_out("e4", 32'h4, rom_word(32'h4), 1'b1);
      tick(1);
      check_out("e5", 32'h8, rom_word(32'h8), 1'b1);

      // Stall for five edges: outputs frozen, FIFO fills to depth, requests stop
      stall = 1'b1;
      tick(1);
      check_out("stall1", 32'h8, rom_word(32'h8), 1'b1);
      check("stall1.req", {31'b0, rom_req}, 32'h0);
      tick(4);
      check_out("stall5", 32'h8, rom_word(32'h8), 1'b1);
      check("stall5.req", {31'b0, rom_req}, 32'h0);
      stall = 1'b0;
      tick(1);
      check_out("resume1", 32'hC, rom_word(32'hC), 1'b1);
      check("resume1.req", {31'b0, rom_req}, 32'h1);
      check("resume1.addr", rom_addr, 32'h14);
      tick(1);
      check_out("resume2", 32'h10, rom_word(32'h10), 1'b1);
      tick(1);
      check_out("resume3", 32'h14, rom_word(32'h14), 1'b1);

      // Three wait cycles per request: address held, three bubbles between valid words
      ack_delay = 3;
      tick(1);
      check_out("dly.e14", 32'h18, rom_word(32'h18), 1'b1);
      tick(1);
      check_out("dly.e15", 32'h0, 32'h0, 1'b0);
      check("dly.e15.addr", rom_addr, 32'h1C);
      tick(1);
      check("dly.e16.addr", rom_addr, 32'h1C);
      check("dly.e16.req", {31'b0, rom_req}, 32'h1);
      tick(2);
      check_out("dly.e18", 32'h1C, rom_word(32'h1C), 1'b1);
      tick(3);
      check("dly.e21.valid", {31'b0, inst_valid}, 32'h0);
      tick(1);
      check_out("dly.e22", 32'h20, rom_word(32'h20), 1'b1);
`ifdef FETCH_PERF_CNT_EN
      check("bubble_cnt.phase1", bubble_cnt, 32'd8);
`endif

      // Reset while a request is outstanding
      rst = 1'b1;
      ack_delay = 0;
      tick(1);
      check_out("midrst", 32'h0, 32'h0, 1'b0);
      check("midrst.req", {31'b0, rom_req}, 32'h0);
      check("midrst.addr", rom_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      check("bubble_cnt.reset", bubble_cnt, 32'd0);
`endif
      rst = 1'b0;
      tick(3);
      check_out("f3", 32'h0, rom_word(32'h0), 1'b1);

      // Redirect to 0x100 while the request to 0x8 is outstanding; ack arrives two cycles later
      ack_en = 1'b0;
      tick(1);
      check_out("f4", 32'h4, rom_word(32'h4), 1'b1);
      check("f4.addr", rom_addr, 32'h8);
      redirect = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick(1);
      check_out("redir.f5", 32'h0, 32'h0, 1'b0);
      check("redir.f5.addr", rom_addr, 32'h8);
      check("redir.f5.req", {31'b0, rom_req}, 32'h1);
      redirect = 1'b0;
      tick(1);
      check("drop.f6.addr", rom_addr, 32'h8);
      ack_force = 1'b1;
      tick(1);
      check("drop.f7.addr", rom_addr, 32'h100);
      check("drop.f7.valid", {31'b0, inst_valid}, 32'h0);
      ack_force = 1'b0;
      ack_en = 1'b1;
      tick(1);
      check("drop.f8.valid", {31'b0, inst_valid}, 32'h0);
      tick(1);
      check_out("redir.f9", 32'h100, rom_word(32'h100), 1'b1);

      // Redirect coinciding with ack and stall; low target bits are cleared
      stall = 1'b1;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0203;
      tick(1);
      check_out("coinc.f10", 32'h0, 32'h0, 1'b0);
      check("coinc.f10.addr", rom_addr, 32'h200);
      check("coinc.f10.req", {31'b0, rom_req}, 32'h1);
      stall = 1'b0;
      redirect = 1'b0;
      tick(1);
      check("coinc.f11.valid", {31'b0, inst_valid}, 32'h0);
      tick(1);
      check_out("coinc.f12", 32'h200, rom_word(32'h200), 1'b1);
`ifdef FETCH_PERF_CNT_EN
      check("bubble_cnt.phase2", bubble_cnt, 32'd6);
`endif
      tick(1);
      check_out("coinc.f13", 32'h204, rom_word(32'h204), 1'b1);

      // PC wrap from START_PC = FFFF_FFF8
      rst_w = 1'b0;
      tick(1);
      check("wrap.g1.addr", rom_addr_w, 32'hFFFF_FFF8);
      check("wrap.g1.req", {31'b0, rom_req_w}, 32'h1);
      tick(2);
      check("wrap.g3.pc", pc_w, 32'hFFFF_FFF8);
      check("wrap.g3.inst", inst_w, rom_word(32'hFFFF_FFF8));
      tick(1);
      check("wrap.g4.pc", pc_w, 32'hFFFF_FFFC);
      tick(1);
      check("wrap.g5.pc", pc_w, 32'h0000_0000);
      check("wrap.g5.inst", inst_w, rom_word(32'h0));
      check("wrap.g5.valid", {31'b0, inst_valid_w}, 32'h1);
`ifdef FETCH_PERF_CNT_EN
      check("wrap.bubble_cnt", bubble_cnt_w, 32'd2);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
